// File: rtl/accum_stage.sv
// accum_stage: registered accumulator that sums a group of unsigned operands
// through a full-adder ripple chain and presents total, beat count and a
// sticky overflow flag on a registered output handshake.
module accum_stage #(
   parameter int size      = 4,
   parameter int acc_width = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [size-1:0]      in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [acc_width-1:0] out_sum,
   output logic [7:0]           out_count,
   output logic                 out_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   alive;
   logic [acc_width-1:0]   acc;
   logic [acc_width-1:0]   addend;
   logic [acc_width-1:0]   sum;
   logic [acc_width:0]     carry;
   logic [7:0]             count;
   logic                   ovf;
   logic                   accept;
   logic                   consume;

   assign addend   = acc_width'(in_data);
   assign carry[0] = 1'b0;

   // One full adder per accumulator bit; the carry ripples LSB to MSB and the
   // carry out of the top stage is the overflow event for this beat.
   for (genvar i = 0; i < acc_width; i++) begin : g_fa
      assign sum[i]       = acc[i] ^ addend[i] ^ carry[i];
      assign carry[i + 1] = (acc[i] & addend[i]) | (carry[i] & (acc[i] ^ addend[i]));
   end

   // Held low through reset and set on the first edge afterwards, so in_ready
   // stays low while rst is high without a combinational path from rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alive <= 1'b0;
      end else begin
         alive <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode, driven only by registered state.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      consume    = 1'b0;
      case (state)
         IDLE, ACC: begin
            in_ready = alive;
            accept   = in_valid & alive;
            if (accept) begin
               state_next = in_last ? HOLD : ACC;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            consume   = out_ready;
            if (consume) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Accumulator, beat counter and sticky overflow; the first beat of a group
   // overwrites whatever the previous group left behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         count <= 8'd0;
         ovf   <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            acc   <= addend;
            count <= 8'd1;
            ovf   <= 1'b0;
         end else begin
            acc   <= sum;
            ovf   <= ovf | carry[acc_width];
            if (count != 8'd255) begin
               count <= count + 8'd1;
            end
         end
      end
   end

   assign out_sum   = acc;
   assign out_count = count;
   assign out_ovf   = ovf;

endmodule

// File: tb/tb_accum_stage.sv
// tb_accum_stage: directed tests for accum_stage with hand-computed results.
module tb_accum_stage;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic [7:0] out_count;
   logic       out_ovf;

   int checks;
   int errors;

   accum_stage #(.size(4), .acc_width(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1, "[TB] timeout");
   end

   // Advance one rising edge, then settle 1 ns past it for sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for exactly one edge; in_valid is left as-is afterwards.
   task automatic beat(input logic [3:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 4'd0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: actual %b required 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: actual %b required 0", out_valid); end
      checks++; if (out_sum !== 8'd0) begin errors++; $display("[TB] FAIL reset_sum: actual %0d required 0", out_sum); end
      checks++; if (out_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: actual %0d required 0", out_count); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: actual %b required 0", out_ovf); end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: actual %b required 1", in_ready); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      beat(4'd3, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: actual %b required 0", out_valid); end
      beat(4'd5, 1'b0);
      beat(4'd7, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: actual %b required 1", out_valid); end
      checks++; if (out_sum !== 8'd15) begin errors++; $display("[TB] FAIL basic_sum: actual %0d required 15", out_sum); end
      checks++; if (out_count !== 8'd3) begin errors++; $display("[TB] FAIL basic_count: actual %0d required 3", out_count); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: actual %b required 0", out_ovf); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_hold_ready: actual %b required 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_one_cycle: actual %b required 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_turnaround: actual %b required 1", in_ready); end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         beat(4'd15, (i == 17));
         if (i == 16) begin
            checks++; if (out_sum !== 8'd255 || out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before_carry: actual sum %0d ovf %b required 255/0", out_sum, out_ovf); end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid: actual %b required 1", out_valid); end
      checks++; if (out_sum !== 8'd14) begin errors++; $display("[TB] FAIL ovf_sum: actual %0d required 14", out_sum); end
      checks++; if (out_count !== 8'd18) begin errors++; $display("[TB] FAIL ovf_count: actual %0d required 18", out_count); end
      checks++; if (out_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: actual %b required 1", out_ovf); end
      tick();
      tick();
      checks++; if (out_ovf !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: actual ovf %b valid %b required 1/1", out_ovf, out_valid); end
      out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ovf_consume: actual %b required 1", in_ready); end
   endtask

   task automatic test_hold();
      out_ready = 1'b0;
      beat(4'd9, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_sum !== 8'd9 || out_count !== 8'd1 || out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL hold_result: actual v%b s%0d c%0d o%b required v1 s9 c1 o0", out_valid, out_sum, out_count, out_ovf); end
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = 4'd5;
         in_last  = 1'b1;
         tick();
         checks++; if (out_valid !== 1'b1 || out_sum !== 8'd9 || out_count !== 8'd1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_stable_%0d: actual v%b s%0d c%0d r%b required v1 s9 c1 r0", i, out_valid, out_sum, out_count, in_ready); end
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: actual r%b v%b required r1 v0", in_ready, out_valid); end
      checks++; if (out_sum !== 8'd9) begin errors++; $display("[TB] FAIL hold_no_accept: actual %0d required 9", out_sum); end
   endtask

   task automatic test_gap();
      out_ready = 1'b1;
      beat(4'd1, 1'b0);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'd1) begin errors++; $display("[TB] FAIL gap_idle_%0d: actual r%b v%b s%0d required r1 v0 s1", i, in_ready, out_valid, out_sum); end
      end
      beat(4'd2, 1'b0);
      beat(4'd4, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_sum !== 8'd7 || out_count !== 8'd3) begin errors++; $display("[TB] FAIL gap_result: actual v%b s%0d c%0d required v1 s7 c3", out_valid, out_sum, out_count); end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      beat(4'd6, 1'b0);
      beat(4'd6, 1'b0);
      in_valid = 1'b0;
      checks++; if (out_sum !== 8'd12 || out_count !== 8'd2) begin errors++; $display("[TB] FAIL midrst_partial: actual s%0d c%0d required s12 c2", out_sum, out_count); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (out_sum !== 8'd0 || out_count !== 8'd0 || out_ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_clear: actual s%0d c%0d o%b v%b r%b required all 0", out_sum, out_count, out_ovf, out_valid, in_ready); end
      tick();
      rst = 1'b0;
      tick();
      beat(4'd2, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_sum !== 8'd2 || out_count !== 8'd1 || out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after: actual v%b s%0d c%0d o%b required v1 s2 c1 o0", out_valid, out_sum, out_count, out_ovf); end
      tick();
   endtask

   task automatic test_saturate();
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         beat(4'd0, (i == 299));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_count !== 8'd255 || out_sum !== 8'd0 || out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL sat_result: actual v%b c%0d s%0d o%b required v1 c255 s0 o0", out_valid, out_count, out_sum, out_ovf); end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_overflow();
      test_hold();
      test_gap();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/accum_stage.md
# accum_stage

Registered accumulator stage that sits directly downstream of the ripple-carry adder datapath. It accepts a stream of `size`-bit operands over a valid/ready handshake and sums them into an `acc_width`-bit register using an internal full-adder ripple chain. When the last operand of a group arrives, it presents the group total, the beat count and a sticky overflow flag on a registered output handshake.

## Interface
- `size`, default 4: operand width in bits (≥1).
- `acc_width`, default 8: accumulator and result width in bits (≥ `size`).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset. Clears all state immediately, independent of `clk`.
- `in_valid` input 1: `in_data`/`in_last` are valid this cycle.
- `in_ready` output 1: stage can accept an operand this cycle.
- `in_data` input `size`: operand, unsigned.
- `in_last` input 1: marks the final operand of the current group.
- `out_valid` output 1: result fields are valid.
- `out_ready` input 1: downstream accepts the result this cycle.
- `out_sum` output `acc_width`: group total, modulo 2^`acc_width`.
- `out_count` output 8: number of operands in the group, saturating at 255.
- `out_ovf` output 1: set if any addition in the group carried out of bit `acc_width`-1.

## Operation
- An operand beat is accepted on a rising edge when `in_valid` and `in_ready` are both high.
- A result is consumed on a rising edge when `out_valid` and `out_ready` are both high.
- Adder: an `acc_width`-stage ripple chain of full adders computes acc + zero-extended `in_data`, with carry-in 0. Carry-out of the top stage is the overflow event. The sum wraps modulo 2^`acc_width`.
- The FSM has three states. Reset state is IDLE.
  - IDLE: `in_ready`=1, `out_valid`=0. On accept: acc ← zero-extended `in_data`, count ← 1, ovf ← 0. Next state is HOLD if `in_last`, else ACC.
  - ACC: `in_ready`=1, `out_valid`=0. On accept: acc ← adder sum, ovf ← ovf | carry-out, count ← min(count+1, 255). Next state is HOLD if `in_last`, else stay in ACC. With no accept, all state holds.
  - HOLD: `in_ready`=0, `out_valid`=1. `out_sum`/`out_count`/`out_ovf` drive the acc/count/ovf registers and stay stable until consumed. On consume, go to IDLE. The registers keep their values; the next IDLE accept overwrites them.
- `in_valid` low in ACC inserts a gap. The group continues; there is no timeout.
- `out_ready` is ignored outside HOLD. `in_valid` is ignored in HOLD.
- Reset values: `in_ready`=0 while `rst` is high and 1 in the first cycle after release. `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0.
- Reset mid-group or mid-HOLD: the partial sum and any pending result are discarded. No output is produced for that group.

## Timing
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from any input to any output.
- Latency: last beat accepted at edge k → `out_valid`=1 and the result is valid in the cycle after edge k.
- Throughput: one operand per cycle while in IDLE/ACC.
- Turnaround: the result consumed at edge m → `in_ready`=1 in the cycle after edge m. That gives a minimum of one cycle with no input acceptance per group (the HOLD cycle).
- A single-beat group (`in_last` on the first beat) goes IDLE→HOLD in one edge, with count=1.
- Critical path: the `acc_width`-bit ripple chain, from acc register to acc register.

## Test plan
- Parameters `size`=4, `acc_width`=8. Beats 3, 5, 7 (`in_last` on 7), back-to-back, `out_ready`=1 → one result: `out_sum`=15, `out_count`=3, `out_ovf`=0. `out_valid` rises the cycle after the 7 is accepted and stays high for exactly one cycle.
- 18 beats of 15, the last with `in_last` → `out_sum`=14 (270 mod 256), `out_count`=18, `out_ovf`=1. Check that `out_ovf` stays set after its first carry-out.
- Single beat 9 with `in_last` → `out_sum`=9, `out_count`=1, `out_ovf`=0. Hold `out_ready` low for 5 cycles: outputs stay stable, `in_ready`=0, and `in_valid` pulses in that window are not accepted. Raise `out_ready` → `in_ready`=1 the next cycle.
- Beats 1, gap of 3 idle cycles, 2, 4 (`in_last`) → `out_sum`=7, `out_count`=3.
- Beats 6, 6, then assert `rst` asynchronously mid-cycle before `in_last` → outputs clear immediately. After release, a single beat 2 with `in_last` → `out_sum`=2, `out_count`=1.
- 300 beats of 0, the last with `in_last` → `out_count`=255 (saturated), `out_sum`=0, `out_ovf`=0.
